// File: rtl/txn_control.sv
// -----------------------------------------------------------------------------
// txn_control
//
// Transaction sequencer for the coin-transfer game with NUM_PLAYERS accounts.
// After reset it writes the initial balance of every account, one per cycle.
// It then uses the load button to walk the user through source, destination,
// amount and key entry. A start request validates the transfer and launches
// the animation/transfer datapath under a watchdog. The outcome is reported as
// a sticky status code.
//
// Parameters
//   NUM_PLAYERS     number of player accounts (2..16)
//   PID_W           player index width, PID_W >= clog2(NUM_PLAYERS)
//   TIMEOUT_CYCLES  maximum number of TRANSACTION cycles before abort (>= 2)
//
// Ports
//   clock                 in   system clock
//   resetn                in   asynchronous active-low reset
//   load_signal           in   level button, high while the current field loads
//   start_signal          in   level, requests the transfer
//   abort_signal          in   level, cancels entry
//   finished_transaction  in   animation datapath done
//   balance_ok            in   source balance >= amount (valid in CHECK)
//   player_sel            in   player index from the switches
//   init_memory           out  write the initial balance at init_addr
//   init_addr             out  account being initialised
//   load_memory           out  display/read balances while idle
//   load_amount           out  amount register enable
//   load_key              out  key register enable
//   src_id, dst_id        out  latched player indices
//   start_transaction     out  high throughout TRANSACTION
//   reset_others          out  active-low datapath reset pulse
//   busy                  out  high in every state except IDLE
//   error_code            out  0 none, 1 invalid player, 2 insufficient funds,
//                              3 timeout
// -----------------------------------------------------------------------------
module txn_control #(
    parameter int NUM_PLAYERS    = 4,
    parameter int PID_W          = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_signal,
    input  logic             start_signal,
    input  logic             abort_signal,
    input  logic             finished_transaction,
    input  logic             balance_ok,
    input  logic [PID_W-1:0] player_sel,
    output logic             init_memory,
    output logic [PID_W-1:0] init_addr,
    output logic             load_memory,
    output logic             load_amount,
    output logic             load_key,
    output logic [PID_W-1:0] src_id,
    output logic [PID_W-1:0] dst_id,
    output logic             start_transaction,
    output logic             reset_others,
    output logic             busy,
    output logic [1:0]       error_code
);

    // The watchdog only has to hold 0..TIMEOUT_CYCLES-1.
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PID_W-1:0] LAST_ADDR = PID_W'(NUM_PLAYERS - 1);
    // One extra bit, so the range check stays meaningful when NUM_PLAYERS
    // equals 2**PID_W.
    localparam logic [PID_W:0]   NP_EXT    = (PID_W + 1)'(NUM_PLAYERS);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PLAYER  = 2'd1;
    localparam logic [1:0] ERR_FUNDS   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_LOAD_SRC,
        S_WAIT_DST,
        S_LOAD_DST,
        S_WAIT_AMT,
        S_LOAD_AMT,
        S_WAIT_KEY,
        S_LOAD_KEY,
        S_WAIT_START,
        S_CHECK,
        S_TRANSACTION,
        S_REJECT,
        S_RESET_OTHERS
    } state_t;

    state_t           state_q, state_d;
    logic [PID_W-1:0] addr_q,  addr_d;
    logic [PID_W-1:0] src_q,   src_d;
    logic [PID_W-1:0] dst_q,   dst_d;
    logic [1:0]       err_q,   err_d;
    logic [WD_W-1:0]  wdog_q,  wdog_d;

    logic             bad_player;

    // A request is malformed if it targets the source account itself or
    // names an account that does not exist.
    always_comb begin
        bad_player = (src_q == dst_q)
                  || ({1'b0, src_q} >= NP_EXT)
                  || ({1'b0, dst_q} >= NP_EXT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            addr_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            err_q   <= ERR_NONE;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        src_d             = src_q;
        dst_d             = dst_q;
        err_d             = err_q;
        wdog_d            = wdog_q;

        init_memory       = 1'b0;
        load_memory       = 1'b0;
        load_amount       = 1'b0;
        load_key          = 1'b0;
        start_transaction = 1'b0;
        reset_others      = 1'b1;
        busy              = 1'b1;

        case (state_q)
            S_INIT: begin
                // One account per cycle; all user inputs are ignored.
                init_memory = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + PID_W'(1);
                end
            end

            S_IDLE: begin
                busy        = 1'b0;
                load_memory = 1'b1;
                if (load_signal) begin
                    // A new request starts with a clean status.
                    err_d   = ERR_NONE;
                    state_d = S_LOAD_SRC;
                end
            end

            // While a field is loading, its register follows the switches
            // every cycle. The value seen on the release cycle is the one kept.
            S_LOAD_SRC: begin
                src_d = player_sel;
                if (abort_signal)      state_d = S_RESET_OTHERS;
                else if (!load_signal) state_d = S_WAIT_DST;
            end

            S_WAIT_DST: begin
                if (abort_signal)     state_d = S_RESET_OTHERS;
                else if (load_signal) state_d = S_LOAD_DST;
            end

            S_LOAD_DST: begin
                dst_d = player_sel;
                if (abort_signal)      state_d = S_RESET_OTHERS;
                else if (!load_signal) state_d = S_WAIT_AMT;
            end

            S_WAIT_AMT: begin
                if (abort_signal)     state_d = S_RESET_OTHERS;
                else if (load_signal) state_d = S_LOAD_AMT;
            end

            S_LOAD_AMT: begin
                load_amount = 1'b1;
                if (abort_signal)      state_d = S_RESET_OTHERS;
                else if (!load_signal) state_d = S_WAIT_KEY;
            end

            S_WAIT_KEY: begin
                if (abort_signal)     state_d = S_RESET_OTHERS;
                else if (load_signal) state_d = S_LOAD_KEY;
            end

            S_LOAD_KEY: begin
                load_key = 1'b1;
                if (abort_signal)      state_d = S_RESET_OTHERS;
                else if (!load_signal) state_d = S_WAIT_START;
            end

            S_WAIT_START: begin
                if (abort_signal)      state_d = S_RESET_OTHERS;
                else if (start_signal) state_d = S_CHECK;
            end

            S_CHECK: begin
                // A player error takes precedence over a funds error.
                if (bad_player) begin
                    err_d   = ERR_PLAYER;
                    state_d = S_REJECT;
                end else if (!balance_ok) begin
                    err_d   = ERR_FUNDS;
                    state_d = S_REJECT;
                end else begin
                    wdog_d  = '0;
                    state_d = S_TRANSACTION;
                end
            end

            S_TRANSACTION: begin
                start_transaction = 1'b1;
                wdog_d            = wdog_q + WD_W'(1);
                // Completion on the last allowed cycle still counts as success.
                if (finished_transaction) begin
                    state_d = S_RESET_OTHERS;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESET_OTHERS;
                end
            end

            S_REJECT: begin
                state_d = S_RESET_OTHERS;
            end

            S_RESET_OTHERS: begin
                reset_others = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign init_addr  = addr_q;
    assign src_id     = src_q;
    assign dst_id     = dst_q;
    assign error_code = err_q;

endmodule
